sub16_seq: RTL and testbench

//   Multi-cycle 16-bit subtractor; the inverse operation of the 8-bit adder in the Add_16bit datapath.

---
 rtl/sub_pkg.sv | 18 +
 rtl/sub_slice.sv | 19 +
 rtl/sub16_seq.sv | 141 ++++++++++++++
 tb/tb_sub16_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants and state encoding for the sliced subtractor
package sub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed overflow of a - b: operand signs differ and the result sign left the minuend's sign
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational SLICE-bit subtract with borrow in/out
module sub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             bin,
  output logic [SLICE-1:0] d_s,
  output logic             bout
);

  // One extra bit catches the borrow: a negative result wraps into the top bit
  logic [SLICE:0] full;

  assign full = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, bin};
  assign d_s  = full[SLICE-1:0];
  assign bout = full[SLICE];

endmodule

// File: rtl/sub16_seq.sv
// rtl/sub16_seq.sv - multi-cycle subtractor, one slice per cycle with rippled borrow
module sub16_seq
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bin_q;
  logic [IW-1:0]    idx;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  logic [SLICE-1:0] a_arr [NSLICE];
  logic [SLICE-1:0] b_arr [NSLICE];
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] d_s;
  logic             bout;
  logic             last_slice;
  logic [WIDTH-1:0] diff_full;

  // Split latched operands into slices so the single subtractor can be muxed by index
  for (genvar g = 0; g < NSLICE; g++) begin : g_split
    assign a_arr[g] = a_q[g*SLICE +: SLICE];
    assign b_arr[g] = b_q[g*SLICE +: SLICE];
  end

  assign a_s        = a_arr[idx];
  assign b_s        = b_arr[idx];
  assign last_slice = (idx == IW'(NSLICE - 1));

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_s  (a_s),
    .b_s  (b_s),
    .bin  (bin_q),
    .d_s  (d_s),
    .bout (bout)
  );

  // Full result as it will stand once the top slice lands, used for the flags
  always_comb begin
    diff_full = diff_q;
    diff_full[(NSLICE-1)*SLICE +: SLICE] = d_s;
  end

  // Control FSM with operand, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bin_q       <= 1'b0;
      idx         <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            bin_q      <= 1'b0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
              diff_q[i*SLICE +: SLICE] <= d_s;
            end
          end
          bin_q <= bout;
          if (last_slice) begin
            idx         <= '0;
            borrow_q    <= bout;
            ovf_q       <= sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_full[WIDTH-1]);
            zero_q      <= (diff_full == '0);
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sub16_seq.sv
// tb/tb_sub16_seq.sv - directed vector bench for sub16_seq
module tb_sub16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[9];
  vec_t b2b[4];

  sub16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input vec_t v);
    check({name, " diff"}, 32'(diff), 32'(v.diff));
    check({name, " borrow"}, 32'(borrow), 32'(v.borrow));
    check({name, " ovf"}, 32'(ovf), 32'(v.ovf));
    check({name, " zero"}, 32'(zero), 32'(v.zero));
  endtask

  // Accept one operand pair and return the number of cycles until out_valid
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready before launch", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int r;
    int j;
    logic acc;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0};

    b2b[0] = '{16'h5555, 16'h1111, 16'h4444, 1'b0, 1'b0, 1'b0};
    b2b[1] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
    b2b[2] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0};
    b2b[3] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow", 32'(borrow), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset zero", 32'(zero), 32'd0);

    // Table vectors with out_ready held high
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d in_ready busy", i), 32'(in_ready), 32'd0);
      check_result($sformatf("vec%0d", i), vecs[i]);
      tick();
      check($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d in_ready back", i), 32'(in_ready), 32'd1);
    end

    // Backpressure holds the result
    out_ready = 1'b0;
    launch(16'hFFFF, 16'h00FF, lat);
    check("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp diff", 32'(diff), 32'hFF00);
      check("bp in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp kept diff", 32'(diff), 32'hFF00);

    // Reset one cycle after accept discards the operation
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid diff", 32'(diff), 32'd0);
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst mid stays idle", 32'(out_valid), 32'd0);
    end
    launch(16'h1234, 16'h0234, lat);
    check("post rst latency", 32'(lat), 32'd2);
    check("post rst diff", 32'(diff), 32'h1000);
    check("post rst borrow", 32'(borrow), 32'd0);
    tick();

    // Back-to-back with in_valid held; operands change right after each accept
    r = 0;
    j = 0;
    in_valid = 1'b1;
    a = b2b[0].a;
    b = b2b[0].b;
    for (int cyc = 0; cyc < 100 && r < 4; cyc++) begin
      if (out_valid) begin
        check_result($sformatf("b2b%0d", r), b2b[r]);
        r++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        j++;
        if (j < 4) begin
          a = b2b[j].a;
          b = b2b[j].b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b result count", 32'(r), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
